// File: rtl/led_chain_driver.sv
// Multi-lane daisy-chain LED driver: reads one word per channel from the frame buffer,
// shifts each lane out under a divided serial clock, then pulses a shared latch.
module led_chain_driver #(
  parameter int c_lanes        = 2,
  parameter int c_channels     = 960,
  parameter int c_addr_w       = $clog2(c_channels),
  parameter int c_bps          = 12,
  parameter int c_div          = 2,
  parameter int c_rd_lat       = 1,
  parameter int c_lat_cycles   = 2,
  parameter int c_msb_first    = 1,
  parameter int c_frame_period = 16666,
  parameter bit c_check_period = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_enable,
  input  logic [c_lanes*c_bps-1:0] i_data,
  output logic [c_addr_w-1:0]      o_addr,
  output logic                     o_read,
  output logic                     o_sclk,
  output logic [c_lanes-1:0]       o_dai,
  output logic                     o_lat,
  output logic                     o_drq,
  output logic                     o_busy,
  output logic                     o_overrun
);

  localparam int c_busy_len = c_channels * (c_rd_lat + 1 + 2 * c_div * c_bps) + c_lat_cycles;
  localparam int c_fc_w     = ($clog2(c_frame_period) > 0) ? $clog2(c_frame_period) : 1;
  localparam int c_bit_w    = $clog2(c_bps + 1);
  localparam int c_div_w    = $clog2(c_div + 1);
  localparam int c_cnt_max  = (c_rd_lat > c_lat_cycles) ? c_rd_lat : c_lat_cycles;
  localparam int c_cnt_w    = $clog2(c_cnt_max + 1);

  localparam logic [c_fc_w-1:0]   c_fc_last    = c_fc_w'(c_frame_period - 1);
  localparam logic [c_bit_w-1:0]  c_bit_last   = c_bit_w'(c_bps - 1);
  localparam logic [c_div_w-1:0]  c_div_last   = c_div_w'(c_div - 1);
  localparam logic [c_cnt_w-1:0]  c_fetch_last = c_cnt_w'(c_rd_lat);
  localparam logic [c_cnt_w-1:0]  c_lat_last   = c_cnt_w'(c_lat_cycles - 1);
  localparam logic [c_addr_w-1:0] c_addr_last  = c_addr_w'(c_channels - 1);

  if (c_div < 1 || c_rd_lat < 1 || c_lat_cycles < 1) begin : g_bad_param
    $error("led_chain_driver: c_div, c_rd_lat and c_lat_cycles must all be at least 1");
  end
  if (c_check_period && c_busy_len >= c_frame_period) begin : g_bad_period
    $error("led_chain_driver: busy frame length must be shorter than c_frame_period");
  end

  typedef enum logic [1:0] {s_idle, s_fetch, s_shift, s_latch} state_t;

  state_t               state, state_n;
  logic [c_fc_w-1:0]    fcnt, fcnt_n;
  logic [c_addr_w-1:0]  addr_n;
  logic [c_cnt_w-1:0]   cnt, cnt_n;
  logic [c_div_w-1:0]   div_cnt, div_cnt_n;
  logic [c_bit_w-1:0]   bit_cnt, bit_cnt_n;
  logic [c_bps-1:0]     sh [c_lanes];
  logic [c_bps-1:0]     sh_n [c_lanes];
  logic [c_lanes-1:0]   dai_n;
  logic                 read_n, sclk_n, lat_n, drq_n, busy_n, overrun_n, tick;

  // Bit that goes on the wire next, and the word left after it has gone.
  function automatic logic head(input logic [c_bps-1:0] w);
    return (c_msb_first != 0) ? w[c_bps-1] : w[0];
  endfunction

  function automatic logic [c_bps-1:0] advance(input logic [c_bps-1:0] w);
    return (c_msb_first != 0) ? (w << 1) : (w >> 1);
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
    state_n   = state;
    addr_n    = o_addr;
    cnt_n     = cnt;
    div_cnt_n = div_cnt;
    bit_cnt_n = bit_cnt;
    sh_n      = sh;
    dai_n     = o_dai;
    sclk_n    = o_sclk;
    read_n    = 1'b0;
    lat_n     = 1'b0;
    drq_n     = 1'b0;
    tick      = (fcnt == '0);
    fcnt_n    = (fcnt == c_fc_last) ? '0 : fcnt + c_fc_w'(1);
    overrun_n = tick && (state != s_idle);

    unique case (state)
      s_idle: if (tick && i_enable) begin
        state_n = s_fetch;
        addr_n  = '0;
        cnt_n   = '0;
        read_n  = 1'b1;
      end
      s_fetch: if (cnt == c_fetch_last) begin
        // Read data is valid now; the first bit goes straight to the pins.
        for (int k = 0; k < c_lanes; k++) begin
          dai_n[k] = head(i_data[k*c_bps +: c_bps]);
          sh_n[k]  = advance(i_data[k*c_bps +: c_bps]);
        end
        state_n   = s_shift;
        div_cnt_n = '0;
        bit_cnt_n = '0;
        sclk_n    = 1'b0;
      end else begin
        cnt_n = cnt + c_cnt_w'(1);
      end
      s_shift: if (div_cnt != c_div_last) begin
        div_cnt_n = div_cnt + c_div_w'(1);
      end else begin
        div_cnt_n = '0;
        if (!o_sclk) begin
          sclk_n = 1'b1;
        end else if (bit_cnt != c_bit_last) begin
          sclk_n    = 1'b0;
          bit_cnt_n = bit_cnt + c_bit_w'(1);
          for (int k = 0; k < c_lanes; k++) begin
            dai_n[k] = head(sh[k]);
            sh_n[k]  = advance(sh[k]);
          end
        end else begin
          sclk_n = 1'b0;
          dai_n  = '0;
          cnt_n  = '0;
          if (o_addr == c_addr_last) begin
            state_n = s_latch;
            lat_n   = 1'b1;
          end else begin
            state_n = s_fetch;
            addr_n  = o_addr + c_addr_w'(1);
            read_n  = 1'b1;
          end
        end
      end
      s_latch: if (cnt == c_lat_last) begin
        state_n = s_idle;
        drq_n   = 1'b1;
      end else begin
        cnt_n = cnt + c_cnt_w'(1);
        lat_n = 1'b1;
      end
      default: state_n = s_idle;
    endcase

    busy_n = (state_n != s_idle);
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= s_idle;
      fcnt      <= '0;
      o_addr    <= '0;
      cnt       <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      // NOTE: the shift registers are only a few flops per lane, so they are reset with the rest.
      for (int k = 0; k < c_lanes; k++) sh[k] <= '0;
      o_dai     <= '0;
      o_sclk    <= 1'b0;
      o_read    <= 1'b0;
      o_lat     <= 1'b0;
      o_drq     <= 1'b0;
      o_busy    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      state     <= state_n;
      fcnt      <= fcnt_n;
      o_addr    <= addr_n;
      cnt       <= cnt_n;
      div_cnt   <= div_cnt_n;
      bit_cnt   <= bit_cnt_n;
      sh        <= sh_n;
      o_dai     <= dai_n;
      o_sclk    <= sclk_n;
      o_read    <= read_n;
      o_lat     <= lat_n;
      o_drq     <= drq_n;
      o_busy    <= busy_n;
      o_overrun <= overrun_n;
    end
  end

endmodule

// File: tb/tb_led_chain_driver.sv
// Bench for led_chain_driver: four configurations run side by side, checked against a
// cycle-position model of the frame plus directed tables and corner sequences.
module tb_led_chain_driver;

  localparam int n_dut = 4;

  // Instance 0 base, 1 LSB-first/div 3, 2 read latency 3, 3 short frame period.
  function automatic int p_div(input int g);
    return (g == 1) ? 3 : 1;
  endfunction
  function automatic int p_lat(input int g);
    return (g == 2) ? 3 : 1;
  endfunction
  function automatic int p_msb(input int g);
    return (g == 1) ? 0 : 1;
  endfunction
  function automatic int p_per(input int g);
    return (g == 1) ? 128 : (g == 3) ? 20 : 64;
  endfunction
  function automatic bit p_chk(input int g);
    return g != 3;
  endfunction

  typedef struct {
    int         t;
    logic       en;
    logic [4:0] exp;   // {busy, read, lat, drq, sclk}
  } vec_t;

  logic       clk = 1'b0;
  logic [3:0] rst_n = '1;
  logic [3:0] en = '0;
  wire  [3:0] rd, sclk, lat, drq, busy, ovr;
  wire  [1:0] addr [n_dut];
  wire  [1:0] dai  [n_dut];
  logic [7:0] mem  [n_dut][3];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < n_dut; g++) begin : g_dut
    logic [3:0] pipe_v = '0;
    logic [1:0] pipe_a [4];
    logic [7:0] rdata;
    logic [1:0] cap [256];
    int         ncap = 0;
    logic       sclk_q = 1'b0;

    // Frame buffer: data appears p_lat cycles after the read strobe, garbage otherwise.
    always @(posedge clk) begin
      pipe_v    <= {pipe_v[2:0], rd[g]};
      pipe_a[0] <= addr[g];
      for (int i = 1; i < 4; i++) pipe_a[i] <= pipe_a[i-1];
    end
    assign rdata = pipe_v[p_lat(g)-1] ? mem[g][pipe_a[p_lat(g)-1]] : 8'hEE;

    // Records the lane bits seen at every serial clock rising edge.
    always @(negedge clk) begin
      sclk_q <= sclk[g];
      if (sclk[g] && !sclk_q) begin
        cap[ncap % 256] <= dai[g];
        ncap <= ncap + 1;
      end
    end

    led_chain_driver #(
      .c_lanes(2), .c_channels(3), .c_bps(4), .c_div(p_div(g)), .c_rd_lat(p_lat(g)),
      .c_lat_cycles(2), .c_msb_first(p_msb(g)), .c_frame_period(p_per(g)),
      .c_check_period(p_chk(g))
    ) u_dut (
      .i_clk(clk), .i_rst_n(rst_n[g]), .i_enable(en[g]), .i_data(rdata),
      .o_addr(addr[g]), .o_read(rd[g]), .o_sclk(sclk[g]), .o_dai(dai[g]),
      .o_lat(lat[g]), .o_drq(drq[g]), .o_busy(busy[g]), .o_overrun(ovr[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic logic [9:0] act_vec(input int g);
    return {busy[g], rd[g], addr[g], sclk[g], dai[g], lat[g], drq[g], ovr[g]};
  endfunction

  function automatic int frame_len(input int g);
    return 3 * (p_lat(g) + 1 + 2 * p_div(g) * 4) + 2;
  endfunction

  // Expected outputs t cycles after the first read strobe, from the frame's timing rules.
  function automatic logic [9:0] exp_vec(input int g, input int t, input int ovr_t);
    int pw, len, w, r, u, s;
    logic e_rd, e_sclk, e_lat;
    logic [1:0] e_addr, e_dai;
    pw     = p_lat(g) + 1 + 2 * p_div(g) * 4;
    len    = frame_len(g);
    e_rd   = 1'b0;
    e_sclk = 1'b0;
    e_lat  = 1'b0;
    e_dai  = '0;
    e_addr = 2'd2;
    if (t < 3 * pw) begin
      w      = t / pw;
      r      = t % pw;
      e_addr = 2'(w);
      e_rd   = (r == 0);
      if (r > p_lat(g)) begin
        u      = r - p_lat(g) - 1;
        s      = u / (2 * p_div(g));
        e_sclk = (u % (2 * p_div(g))) >= p_div(g);
        for (int k = 0; k < 2; k++)
          e_dai[k] = mem[g][w][k*4 + ((p_msb(g) != 0) ? 3 - s : s)];
      end
    end else begin
      e_lat = (t < len);
    end
    return {t < len, e_rd, e_addr, e_sclk, e_dai, e_lat, t == len, t == ovr_t};
  endfunction

  task automatic run_frame(input int g, input int ovr_t, input int budget, output int t0);
    bit found;
    int len;
    found = 1'b0;
    len   = frame_len(g);
    t0    = -1;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      found = rd[g];
    end
    check($sformatf("g%0d frame_start", g), found, 1);
    if (!found) return;
    t0 = cyc;
    for (int t = 0; t <= len; t++) begin
      if (t > 0) @(negedge clk);
      check($sformatf("g%0d t%0d {busy,rd,addr,sclk,dai,lat,drq,ovr}", g, t),
            act_vec(g), exp_vec(g, t, ovr_t));
    end
  endtask

  task automatic scen_a();
    vec_t tbl [13];
    int ri, base, t0;
    bit found, seen;
    logic [11:0] l0, l1;
    logic [1:0] b;
    tbl[0]  = '{0,  1'b1, 5'b11000};
    tbl[1]  = '{1,  1'b1, 5'b10000};
    tbl[2]  = '{2,  1'b1, 5'b10000};
    tbl[3]  = '{3,  1'b1, 5'b10001};
    tbl[4]  = '{5,  1'b0, 5'b10001};
    tbl[5]  = '{10, 1'b0, 5'b11000};
    tbl[6]  = '{11, 1'b0, 5'b10000};
    tbl[7]  = '{20, 1'b0, 5'b11000};
    tbl[8]  = '{29, 1'b0, 5'b10001};
    tbl[9]  = '{30, 1'b0, 5'b10100};
    tbl[10] = '{31, 1'b0, 5'b10100};
    tbl[11] = '{32, 1'b0, 5'b00010};
    tbl[12] = '{33, 1'b0, 5'b00000};
    base  = g_dut[0].ncap;
    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      @(negedge clk);
      found = rd[0];
    end
    check("a_frame_start", found, 1);
    ri = 0;
    for (int t = 0; t <= 33; t++) begin
      if (t > 0) @(negedge clk);
      if (ri < 13 && tbl[ri].t == t) begin
        check($sformatf("a_tbl t%0d {busy,rd,lat,drq,sclk}", t),
              {busy[0], rd[0], lat[0], drq[0], sclk[0]}, tbl[ri].exp);
        en[0] = tbl[ri].en;
        ri++;
      end
    end
    check("a_sclk_rises", g_dut[0].ncap - base, 12);
    l0 = '0;
    l1 = '0;
    for (int i = 0; i < 12; i++) begin
      b  = g_dut[0].cap[(base + i) % 256];
      l0 = {l0[10:0], b[0]};
      l1 = {l1[10:0], b[1]};
    end
    check("a_lane0_bits", l0, 12'b0101_1100_0000);
    check("a_lane1_bits", l1, 12'b1010_0011_1111);

    seen = 1'b0;
    for (int t = 34; t <= 80; t++) begin
      @(negedge clk);
      seen |= rd[0];
    end
    check("a_no_read_while_disabled", seen, 0);

    en[0] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      found = rd[0];
    end
    check("a_restart_after_enable", found, 1);
    repeat (15) @(negedge clk);
    check("a_mid_shift_before_reset {busy,lat}", {busy[0], lat[0]}, 2'b10);
    @(posedge clk);
    #2 rst_n[0] = 1'b0;
    #1 check("a_async_reset_outputs", act_vec(0), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("a_reset_hold %0d", i), act_vec(0), 0);
    end
    for (int i = 0; i < 3; i++) mem[0][i] = 8'($urandom);
    rst_n[0] = 1'b1;
    run_frame(0, -1, 3, t0);
  endtask

  task automatic scen_b();
    int base, t0;
    logic [11:0] l0, l1;
    logic [1:0] b;
    base = g_dut[1].ncap;
    run_frame(1, -1, 5, t0);
    check("b_sclk_rises", g_dut[1].ncap - base, 12);
    l0 = '0;
    l1 = '0;
    for (int i = 0; i < 12; i++) begin
      b  = g_dut[1].cap[(base + i) % 256];
      l0 = {l0[10:0], b[0]};
      l1 = {l1[10:0], b[1]};
    end
    check("b_lane0_bits", l0, 12'b1010_0011_0000);
    check("b_lane1_bits", l1, 12'b0101_1100_1111);
  endtask

  task automatic scen_c();
    int t0;
    for (int f = 0; f < 3; f++) begin
      run_frame(2, -1, 80, t0);
      for (int i = 0; i < 3; i++) mem[2][i] = 8'($urandom);
    end
  endtask

  task automatic scen_d();
    int t0a, t0b;
    run_frame(3, 20, 5, t0a);
    for (int i = 0; i < 3; i++) mem[3][i] = 8'($urandom);
    run_frame(3, 20, 20, t0b);
    check("d_frame_spacing", t0b - t0a, 40);
  endtask

  initial begin
    for (int g = 0; g < n_dut; g++) begin
      mem[g][0] = 8'hA5;
      mem[g][1] = 8'h3C;
      mem[g][2] = 8'hF0;
    end
    for (int i = 0; i < 3; i++) mem[2][i] = 8'($urandom);
    en = '1;
    #1 rst_n = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < n_dut; g++) check($sformatf("g%0d reset_outputs", g), act_vec(g), 0);
    rst_n = '1;
    fork
      scen_a();
      scen_b();
      scen_c();
      scen_d();
    join
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary in time");
    $fatal(1, "watchdog expired");
  end

endmodule
